// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - Bus bundle between both data-memory requesters, the arbiter and the data RAM
//
// Purpose: groups the port 0 / port 1 request and response signals and the
//          RAM control signals of dmem_arbiter into one interface.
// Modports:
//   slave  : the arbiter. It takes the requests and mem_rdata, and drives the
//            grants, read responses and RAM controls.
//   master : the requesters and RAM model. It is the mirror image of slave.
// Signals:
//   pN_req, pN_we, pN_lock       request, write select, hold-grant request
//   pN_addr, pN_wdata            byte address and write data
//   pN_gnt                       access issued this cycle
//   pN_rvalid, pN_rdata          registered read response
//   mem_wen, mem_ren             RAM write and read enables
//   mem_waddr, mem_raddr         RAM addresses
//   mem_wdata                    RAM write data
//   mem_rdata                    RAM read data, valid the cycle after mem_ren

interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  p0_req;
  logic                  p0_we;
  logic                  p0_lock;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_gnt;
  logic                  p0_rvalid;
  logic [DATA_WIDTH-1:0] p0_rdata;

  logic                  p1_req;
  logic                  p1_we;
  logic                  p1_lock;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_gnt;
  logic                  p1_rvalid;
  logic [DATA_WIDTH-1:0] p1_rdata;

  logic                  mem_wen;
  logic                  mem_ren;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_wen, mem_ren, mem_waddr, mem_raddr, mem_wdata
  );

  modport master (
    output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_wen, mem_ren, mem_waddr, mem_raddr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - Two-port data-memory arbiter with bounded bus lock
//
// Purpose: shares one data RAM between the core load/store path (port 0) and
//          the loader/debug path (port 1). It issues at most one access per
//          cycle and routes each read response back to the port that issued it.
//          A port asserting lock keeps the grant for up to LOCK_MAX consecutive
//          cycles.
// Parameters: ADDR_WIDTH, DATA_WIDTH, LOCK_MAX (>= 1)
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous, active-low reset
//   bus  : dmem_arbiter_if.slave, which carries the requests, grants, read
//          responses and RAM controls
// Build option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin contention
//   resolution. When it is undefined, port 0 has fixed priority.

module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_MAX   = 4
) (
  input  logic            clk,
  input  logic            rst,
  dmem_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_P0   = 2'd1,
    LOCK_P1   = 2'd2
  } lock_state_t;

  lock_state_t      lock_state, lock_state_next;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             held;

  logic             gnt0, gnt1;
  logic             pol0, pol1;

  logic             rd_valid;
  logic             rd_port;

  // Contention policy, used whenever no active lock holder is requesting.
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic rr_last;

  always_comb begin
    pol0 = 1'b0;
    pol1 = 1'b0;
    if (bus.p0_req && bus.p1_req) begin
      // The port that was not granted most recently wins.
      pol0 = rr_last;
      pol1 = ~rr_last;
    end else begin
      pol0 = bus.p0_req;
      pol1 = bus.p1_req;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last <= 1'b1;
    end else if (gnt0) begin
      rr_last <= 1'b0;
    end else if (gnt1) begin
      rr_last <= 1'b1;
    end
  end
`else
  always_comb begin
    pol0 = bus.p0_req;
    pol1 = bus.p1_req & ~bus.p0_req;
  end
`endif

  // Lock state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_state <= LOCK_NONE;
      lock_cnt   <= '0;
    end else begin
      lock_state <= lock_state_next;
      lock_cnt   <= lock_cnt_next;
    end
  end

  // Grant selection and next lock state. The lock survives only while the
  // granted port keeps lock asserted. An idle cycle, an unlocked grant or
  // reaching LOCK_MAX all return the arbiter to the policy.
  always_comb begin
    gnt0            = 1'b0;
    gnt1            = 1'b0;
    lock_state_next = LOCK_NONE;
    lock_cnt_next   = '0;
    cnt_inc         = '0;
    held            = 1'b0;

    case (lock_state)
      LOCK_P0: begin
        if (bus.p0_req) begin
          gnt0 = 1'b1;
        end else begin
          gnt0 = pol0;
          gnt1 = pol1;
        end
      end
      LOCK_P1: begin
        if (bus.p1_req) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = pol0;
          gnt1 = pol1;
        end
      end
      default: begin
        gnt0 = pol0;
        gnt1 = pol1;
      end
    endcase

    if ((gnt0 && bus.p0_lock) || (gnt1 && bus.p1_lock)) begin
      held    = gnt0 ? (lock_state == LOCK_P0) : (lock_state == LOCK_P1);
      // A fresh lock counts its first grant as 1.
      cnt_inc = held ? (lock_cnt + CNT_W'(1)) : CNT_W'(1);
      if (cnt_inc != LOCK_MAX_C) begin
        lock_state_next = gnt0 ? LOCK_P0 : LOCK_P1;
        lock_cnt_next   = cnt_inc;
      end
    end
  end

  // RAM controls follow the granted port. They are all zero when no port is granted.
  always_comb begin
    bus.p0_gnt    = gnt0;
    bus.p1_gnt    = gnt1;
    bus.mem_wen   = 1'b0;
    bus.mem_ren   = 1'b0;
    bus.mem_waddr = '0;
    bus.mem_raddr = '0;
    bus.mem_wdata = '0;
    if (gnt0) begin
      bus.mem_wen   = bus.p0_we;
      bus.mem_ren   = ~bus.p0_we;
      bus.mem_waddr = bus.p0_addr;
      bus.mem_raddr = bus.p0_addr;
      bus.mem_wdata = bus.p0_wdata;
    end else if (gnt1) begin
      bus.mem_wen   = bus.p1_we;
      bus.mem_ren   = ~bus.p1_we;
      bus.mem_waddr = bus.p1_addr;
      bus.mem_raddr = bus.p1_addr;
      bus.mem_wdata = bus.p1_wdata;
    end
  end

  // Read-owner tracking. A read in flight when reset asserts is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_port  <= 1'b0;
    end else begin
      rd_valid <= bus.mem_ren;
      rd_port  <= gnt1;
    end
  end

  always_comb begin
    bus.p0_rvalid = rd_valid & ~rd_port;
    bus.p1_rvalid = rd_valid & rd_port;
    bus.p0_rdata  = (rd_valid && !rd_port) ? bus.mem_rdata : '0;
    bus.p1_rdata  = (rd_valid && rd_port) ? bus.mem_rdata : '0;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory between the core load/store path (port 0) and the program-loader/debug path (port 1). It sits between both requesters and the data RAM instance. It grants at most one access per cycle, drives the RAM write and read controls, and routes each read response back to the port that issued it. An optional bus lock gives a port consecutive grants for read-modify-write sequences, bounded by a hold limit.

## Interface
- ADDR_WIDTH, 32, address width of ports and memory
- DATA_WIDTH, 32, data width of ports and memory
- LOCK_MAX, 4, maximum consecutive locked grants to one port (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- p0_req / p1_req  in  1  access request
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_lock / p1_lock  in  1  request that the grant be kept next cycle
- p0_addr / p1_addr  in  ADDR_WIDTH  byte address
- p0_wdata / p1_wdata  in  DATA_WIDTH  write data
- p0_gnt / p1_gnt  out  1  access issued to memory this cycle
- p0_rvalid / p1_rvalid  out  1  read data valid (registered)
- p0_rdata / p1_rdata  out  DATA_WIDTH  read data
- mem_wen, mem_ren  out  1  RAM write / read enable
- mem_waddr, mem_raddr  out  ADDR_WIDTH  RAM addresses
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after mem_ren

## Operation
- Grant is combinational from the current req/lock inputs and the registered state.
- p0_gnt and p1_gnt are never 1 together. A port with req=0 is never granted.
- Granted port's addr drives both mem_waddr and mem_raddr. Its wdata drives mem_wdata.
- mem_wen = granted & we. mem_ren = granted & ~we.
- With no grant: mem_wen = mem_ren = 0. Addresses and wdata are 0.
- Arbitration order:
  - Active lock holder wins if it is requesting.
  - Otherwise the policy decides (see Configuration).
- Lock state:
  - Registered `lock_owner` (none/0/1) and `lock_cnt`.
  - When the granted port has lock=1, lock_owner is set to that port and lock_cnt increments. lock_cnt starts at 1 on the first locked grant.
  - When lock_cnt reaches LOCK_MAX, the lock is released: lock_owner = none and lock_cnt = 0. The next arbitration uses the policy, even if lock is still asserted.
  - Lock holder grant with lock=0, or lock holder req=0, releases immediately.
- Read response:
  - A registered `rd_owner` records the port granted a read.
  - Next cycle, that port's rvalid = 1 and its rdata = mem_rdata.
  - The non-owner's rdata is 0.
  - Writes produce no rvalid.
- Back-to-back reads from alternating ports are allowed. Each response goes to the correct port.

## Timing
- Grant and memory controls: 0-cycle latency. Read data: exactly 1 cycle after grant. Throughput: 1 access/cycle.
- Reset (rst=0, async):
  - rvalid = 0 on both ports. rd_owner = none.
  - lock_owner = none. lock_cnt = 0. rr_last = 1, so port 0 wins the first contention.
  - Combinational outputs follow their inputs. gnt depends only on req.
- Reset asserted while a read is in flight: the response is dropped, and no rvalid follows after release.
- Simultaneous req with no lock: resolved by policy in the same cycle. The loser holds its inputs stable until granted.
- LOCK_MAX=1: lock never yields consecutive grants under contention.

## Configuration
- DMEM_ARB_ROUND_ROBIN_EN defined:
  - Round-robin policy. Registered `rr_last` updates to the granted port on every grant.
  - Under contention, the port that is not rr_last wins.
- Not defined:
  - Fixed priority. Port 0 always wins contention outside a lock.
  - rr_last is absent.
- Lock behaviour is identical in both builds.

## Test plan
- Reset release, then p0 read addr 0x10 with mem_rdata=0xDEADBEEF next cycle -> p0_gnt=1 and mem_ren=1 in cycle 0; p0_rvalid=1 and p0_rdata=0xDEADBEEF in cycle 1; p1_rvalid=0.
- p0 and p1 both request continuously for 6 cycles, no lock. With RR: grants 0,1,0,1,0,1. Without the macro: six grants to p0.
- p1 writes 0x55 to 0x20 with lock=1 held, p0 requesting, LOCK_MAX=4 -> p1 granted 4 consecutive cycles, then p0 granted on cycle 5.
- p0 read granted at cycle 0, p1 read granted at cycle 1 -> p0_rvalid at cycle 1 with cycle-1 mem_rdata; p1_rvalid at cycle 2 with cycle-2 mem_rdata; never both rvalid together.
- p1 read granted, rst pulsed low before the next clk edge -> no p1_rvalid. After release, lock and pointer are at reset values, and first contention goes to p0.
